seq_mult: RTL and testbench

Iterative unsigned shift-and-add multiplier, the control and datapath stage directly upstream of the team's ripple-carry `adder` module. Each cycle it feeds that adder the running partial product and the multiplicand, then consumes the adder's sum and carry-out. One multiplication of two DATA_WIDTH-bit operands completes in DATA_WIDTH iteration cycles and produces a 2·DATA_WIDTH-bit product. The block is the sequential baseline in the multiplier area/latency comparison.

---
 rtl/seq_mult.sv | 81 ++++++++
 tb/tb_seq_mult.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// seq_mult: iterative unsigned shift-and-add multiplier driving a ripple-carry adder, one bit per cycle.
module adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  co
);
  logic c;
  always_comb begin
    c = 1'b0;
    sum = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end
endmodule

module seq_mult #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    ready,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] mcand, acc, mplr, sum;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] product_q, shifted;
  logic co, last;
  adder #(.DATA_WIDTH(W)) u_adder (
    .a(acc),
    .b(mplr[0] ? mcand : '0),
    .sum(sum),
    .co(co)
  );
  // carry-out lands in the acc MSB so no product bit is ever lost
  assign shifted = {co, sum, mplr[W-1:1]};
  assign last = cnt == LAST;
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = RUN;
    else if (state == RUN && last) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mcand <= '0;
      acc <= '0;
      mplr <= '0;
      cnt <= '0;
      product_q <= '0;
    end else if (state == IDLE && start) begin
      mcand <= a;
      acc <= '0;
      mplr <= b;
      cnt <= '0;
    end else if (state == RUN) begin
      {acc, mplr} <= shifted;
      cnt <= cnt + 1'b1;
      if (last) product_q <= shifted;
    end
  assign ready = state == IDLE;
  assign done = state == DONE;
  assign product = product_q;
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed checks of seq_mult at W=8 and W=32 against hand-computed products.
module tb_seq_mult;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, start32 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic ready8, done8, ready32, done32;
  logic [15:0] product8;
  logic [63:0] product32;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  seq_mult #(.DATA_WIDTH(8)) d8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .product(product8)
  );
  seq_mult #(.DATA_WIDTH(32)) d32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .ready(ready32), .done(done32), .product(product32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input logic s, input logic [31:0] x, input logic [31:0] y);
    if (w) begin start32 = s; a32 = x; b32 = y; end
    else begin start8 = s; a8 = x[7:0]; b8 = y[7:0]; end
  endtask

  function automatic logic rdy(input bit w);
    return w ? ready32 : ready8;
  endfunction

  function automatic logic dn(input bit w);
    return w ? done32 : done8;
  endfunction

  function automatic logic [63:0] prod(input bit w);
    return w ? product32 : {48'b0, product8};
  endfunction

  task automatic op(input bit w, input logic [31:0] x, input logic [31:0] y,
                    input logic [63:0] e, input string tag, input bit busy);
    int n = 0;
    int wd = w ? 32 : 8;
    @(negedge clk);
    drive(w, 1'b1, x, y);
    @(posedge clk); #1;
    chk({tag, "_ready_fall"}, rdy(w), 0);
    drive(w, 1'b0, ~x, ~y);
    while (!dn(w) && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy && n == 2) drive(w, 1'b1, 32'h77, 32'h77);
      if (busy && n == 3) drive(w, 1'b0, 32'h0, 32'h0);
    end
    chk({tag, "_latency"}, n, wd);
    chk({tag, "_product"}, prod(w), e);
    chk({tag, "_ready_in_done"}, rdy(w), 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, dn(w), 0);
    chk({tag, "_ready_back"}, rdy(w), 1);
    chk({tag, "_product_hold"}, prod(w), e);
  endtask

  initial begin
    int n, cnt_done;
    logic [31:0] x, y;
    #1;
    chk("rst_ready8", ready8, 1);
    chk("rst_done8", done8, 0);
    chk("rst_prod8", product8, 0);
    chk("rst_prod32", product32, 0);
    @(negedge clk); rst = 1'b0;
    op(0, 32'h0D, 32'h0B, 64'h008F, "d0d_0b", 0);
    op(0, 32'hFF, 32'hFF, 64'hFE01, "ff_ff", 0);
    op(0, 32'h00, 32'hA5, 64'h0000, "zero_a5", 0);
    op(0, 32'hA5, 32'h00, 64'h0000, "a5_zero", 0);
    op(0, 32'h0D, 32'h0B, 64'h008F, "busy", 1);
    cnt_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) cnt_done++;
    end
    chk("busy_no_second_done", cnt_done, 0);
    // back-to-back with start held high
    @(negedge clk); drive(0, 1'b1, 32'd3, 32'd5);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 3) drive(0, 1'b1, 32'hEE, 32'h99);
    end while (!done8 && n < 40);
    chk("b2b_first", product8, 16'h000F);
    drive(0, 1'b1, 32'd200, 32'd2);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 3) drive(0, 1'b1, 32'h11, 32'h22);
    end while (!done8 && n < 40);
    chk("b2b_period", n, 10);
    chk("b2b_second", product8, 16'h0190);
    drive(0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("b2b_ready", ready8, 1);
    // asynchronous reset in the middle of a run
    @(negedge clk); drive(0, 1'b1, 32'hFF, 32'hFF);
    @(posedge clk); #1; drive(0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_ready", ready8, 1);
    chk("arst_done", done8, 0);
    chk("arst_prod", product8, 0);
    @(negedge clk); rst = 1'b0;
    op(0, 32'h12, 32'h34, 64'h03A8, "after_rst", 0);
    op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, "w32_max", 0);
    op(1, 32'h00000000, 32'hDEADBEEF, 64'h0, "w32_zero", 0);
    op(1, 32'h00010000, 32'h00010000, 64'h0000000100000000, "w32_pow2", 0);
    op(1, 32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E242D2080, "w32_mix", 0);
    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      y = $urandom;
      op(1, x, y, {32'b0, x} * {32'b0, y}, "w32_rand", 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
